lane_stream_coprocessor: RTL and testbench

//   Parametrised successor of the single-lane coprocessor: din carries NUM_LANES packed

---
 rtl/lane_cop_pkg.sv | 14 +
 rtl/lane_stream_coprocessor_if.sv | 16 +
 rtl/lane_stream_coprocessor_sync_fifo.sv | 62 ++++++
 rtl/lane_stream_coprocessor.sv | 95 +++++++++
 tb/tb_lane_stream_coprocessor.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/lane_cop_pkg.sv
// Shared mode encodings and control-bit positions for the lane stream coprocessor.
package lane_cop_pkg;

  typedef enum logic [2:0] {
    MODE_PAIRSUM = 3'd0,
    MODE_PASS    = 3'd1,
    MODE_DELAY2  = 3'd2,
    MODE_ACCUM   = 3'd3
  } lane_mode_e;

  localparam int CTRL_SAT = 3;
  localparam int CTRL_CLR = 4;

endpackage

// File: rtl/lane_stream_coprocessor_if.sv
// Stream bus: packed-lane input beat with valid/ready, result head with valid/ready.
interface lane_stream_if #(parameter int WIDTH = 128);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic [5:0]       control;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             overflow;

  modport master (output din, din_valid, control, dout_ready,
                  input  din_ready, dout, dout_valid, overflow);
  modport slave  (input  din, din_valid, control, dout_ready,
                  output din_ready, dout, dout_valid, overflow);
endinterface

// File: rtl/lane_stream_coprocessor_sync_fifo.sv
// Flop-based synchronous FIFO; head is presented combinationally, zero when empty.
module sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/lane_stream_coprocessor.sv
// Lane-wise stream transform (pass / delay-2 / pair-sum / accumulate) feeding an output FIFO.
module lane_stream_coprocessor
  import lane_cop_pkg::*;
#(
  parameter int NUM_LANES  = 8,
  parameter int LANE_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  lane_stream_if.slave  bus
);
  localparam int WIDTH = NUM_LANES * LANE_W;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [NUM_LANES-1:0][LANE_W-1:0] din_l, res_l;
  logic [NUM_LANES-1:0][LANE_W-1:0] hist1_q, hist1_d, hist2_q, hist2_d, acc_q, acc_d;
  logic [NUM_LANES-1:0]             carry_l;
  logic                             ovf_q, ovf_d;
  logic [2:0]                       mode;
  logic                             sat, clr, is_add, accept;
  logic [CW-1:0]                    fifo_count;
  logic                             fifo_empty, fifo_full_unused;
  logic                             unused_ctrl;

  assign din_l       = bus.din;
  assign mode        = bus.control[2:0];
  assign sat         = bus.control[CTRL_SAT];
  assign clr         = bus.control[CTRL_CLR];
  assign unused_ctrl = bus.control[5];
  assign is_add      = (mode == MODE_PAIRSUM) || (mode == MODE_ACCUM);
  assign accept      = bus.din_valid & bus.din_ready;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [LANE_W-1:0] addend, arith;
    logic [LANE_W:0]   sum;
    assign addend     = (mode == MODE_ACCUM) ? acc_q[i] : hist1_q[i];
    assign sum        = {1'b0, addend} + {1'b0, din_l[i]};
    assign arith      = (sum[LANE_W] && sat) ? {LANE_W{1'b1}} : sum[LANE_W-1:0];
    assign carry_l[i] = sum[LANE_W] & is_add;
    assign res_l[i]   = is_add ? arith :
                        (mode == MODE_DELAY2) ? hist2_q[i] : din_l[i];
  end

  always_comb begin
    hist1_d = hist1_q;
    hist2_d = hist2_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (accept) begin
      hist2_d = hist1_q;
      hist1_d = din_l;
      if (mode == MODE_ACCUM) acc_d = res_l;
      if (|carry_l) ovf_d = 1'b1;
    end
    // Clear wins over this edge's updates, except the accepted beat still seeds hist1.
    if (clr) begin
      hist2_d = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
      if (!accept) hist1_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist1_q <= '0;
      hist2_q <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      hist1_q <= hist1_d;
      hist2_q <= hist2_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata (res_l),
    .pop   (bus.dout_ready),
    .rdata (bus.dout),
    .full  (fifo_full_unused),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.din_ready  = (fifo_count < DEPTH_C);
  assign bus.dout_valid = ~fifo_empty;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_lane_stream_coprocessor.sv
// Directed self-checking bench for lane_stream_coprocessor (8 lanes x 16 bits, FIFO depth 4).
module tb_lane_stream_coprocessor;
  import lane_cop_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lane_stream_if #(.WIDTH(128)) bus();

  lane_stream_coprocessor #(.NUM_LANES(8), .LANE_W(16), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [5:0] C_PS  = 6'h00;
  localparam logic [5:0] C_PA  = 6'h01;
  localparam logic [5:0] C_D2  = 6'h02;
  localparam logic [5:0] C_AC  = 6'h03;
  localparam logic [5:0] C_SAT = 6'h08;
  localparam logic [5:0] C_CLR = 6'h10;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [127:0] d, input logic [5:0] c);
    int w;
    w = 0;
    while (!bus.din_ready && w < 20) begin
      tick;
      w++;
    end
    if (!bus.din_ready) chk("din_ready_timeout", 128'(bus.din_ready), 128'd1);
    bus.din       = d;
    bus.din_valid = 1'b1;
    bus.control   = c;
    tick;
    bus.din_valid = 1'b0;
    bus.control   = '0;
    bus.din       = '0;
  endtask

  task automatic clear_edge;
    bus.control = C_CLR;
    tick;
    bus.control = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick;
  endtask

  logic [15:0] got_q [8];
  int sent, n_got;
  logic acc_now;

  initial begin
    rst            = 1'b1;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.control    = '0;
    bus.dout_ready = 1'b0;
    #2;
    chk("rst_dout_valid", 128'(bus.dout_valid), 128'd0);
    chk("rst_dout",       bus.dout,             128'd0);
    chk("rst_din_ready",  128'(bus.din_ready),  128'd1);
    chk("rst_overflow",   128'(bus.overflow),   128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick;

    // 1: pass-through, 1-cycle latency, full lane packing
    bus.dout_ready = 1'b1;
    beat(128'h0001, C_PA);
    chk("t1_valid0", 128'(bus.dout_valid), 128'd1);
    chk("t1_dout0",  bus.dout, 128'h0001);
    beat(128'h0002, C_PA);
    chk("t1_dout1",  bus.dout, 128'h0002);
    beat(128'h0008_0007_0006_0005_0004_0003_0002_0001, C_PA);
    chk("t1_lanes",  bus.dout, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    tick;
    chk("t1_drained", 128'(bus.dout_valid), 128'd0);

    // 2: delay-2 after reset, then pair-sum
    do_reset;
    beat(128'd3, C_D2); chk("t2_d2_a", bus.dout, 128'd0);
    beat(128'd4, C_D2); chk("t2_d2_b", bus.dout, 128'd0);
    beat(128'd5, C_D2); chk("t2_d2_c", bus.dout, 128'd3);
    beat(128'd6, C_PS); chk("t2_ps",   bus.dout, 128'd11);
    tick;

    // 3: accumulate wrap vs saturate, sticky overflow and clear
    clear_edge;
    beat(128'hFFF0, C_AC);         chk("t3_w_a",   bus.dout, 128'hFFF0);
    chk("t3_w_ovf0", 128'(bus.overflow), 128'd0);
    beat(128'h0020, C_AC);         chk("t3_w_b",   bus.dout, 128'h0010);
    chk("t3_w_ovf1", 128'(bus.overflow), 128'd1);
    beat(128'h0001, C_AC);         chk("t3_w_acc", bus.dout, 128'h0011);
    chk("t3_w_stky", 128'(bus.overflow), 128'd1);
    clear_edge;
    chk("t3_clr0",   128'(bus.overflow), 128'd0);
    beat(128'hFFF0, C_AC | C_SAT); chk("t3_s_a",   bus.dout, 128'hFFF0);
    beat(128'h0020, C_AC | C_SAT); chk("t3_s_b",   bus.dout, 128'hFFFF);
    chk("t3_s_ovf",  128'(bus.overflow), 128'd1);
    beat(128'h0000, C_AC | C_SAT); chk("t3_s_acc", bus.dout, 128'hFFFF);
    clear_edge;
    chk("t3_clr1",   128'(bus.overflow), 128'd0);

    // clear together with a beat: result uses old history, hist1 keeps the beat
    beat(128'd9, C_PA);
    beat(128'd5, C_PS | C_CLR);    chk("t3_cb_res", bus.dout, 128'd14);
    beat(128'd1, C_PS);            chk("t3_cb_h1",  bus.dout, 128'd6);
    beat(128'd2, C_D2);            chk("t3_cb_h2",  bus.dout, 128'd5);
    tick;

    // 4: backpressure, 6 offered with FIFO depth 4
    bus.dout_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      bus.din       = 128'(16'h0040 + 16'(sent));
      bus.din_valid = 1'b1;
      bus.control   = C_PA;
      acc_now       = bus.din_ready;
      tick;
      if (acc_now) sent++;
    end
    chk("t4_accepted",  128'(sent), 128'd4);
    chk("t4_din_ready", 128'(bus.din_ready), 128'd0);
    chk("t4_head",      bus.dout, 128'h0040);
    bus.dout_ready = 1'b1;
    n_got = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.dout_valid && n_got < 8) begin
        got_q[n_got] = bus.dout[15:0];
        n_got++;
      end
      if (sent < 6) begin
        bus.din       = 128'(16'h0040 + 16'(sent));
        bus.din_valid = 1'b1;
      end else begin
        bus.din_valid = 1'b0;
      end
      acc_now = bus.din_ready && (sent < 6);
      tick;
      if (acc_now) sent++;
      if (sent == 6 && n_got == 6 && !bus.dout_valid) break;
    end
    bus.din_valid = 1'b0;
    bus.control   = '0;
    chk("t4_count", 128'(n_got), 128'd6);
    for (int k = 0; k < 6; k++)
      if (k < n_got) chk($sformatf("t4_order%0d", k), 128'(got_q[k]), 128'(16'h0040 + 16'(k)));
    chk("t4_empty", 128'(bus.dout_valid), 128'd0);

    // 5: simultaneous push and pop with 2 queued
    bus.dout_ready = 1'b0;
    beat(128'h51, C_PA);
    beat(128'h52, C_PA);
    chk("t5_head0", bus.dout, 128'h51);
    bus.dout_ready = 1'b1;
    beat(128'h53, C_PA);
    chk("t5_head1", bus.dout, 128'h52);
    chk("t5_ready", 128'(bus.din_ready), 128'd1);
    tick;
    chk("t5_head2", bus.dout, 128'h53);
    tick;
    chk("t5_empty", 128'(bus.dout_valid), 128'd0);

    // 6: async reset with 3 queued
    bus.dout_ready = 1'b0;
    beat(128'h61, C_PA);
    beat(128'h62, C_PA);
    beat(128'h63, C_PA);
    chk("t6_queued", 128'(bus.dout_valid), 128'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid",  128'(bus.dout_valid), 128'd0);
    chk("t6_ready",  128'(bus.din_ready),  128'd1);
    chk("t6_dout",   bus.dout,             128'd0);
    #1;
    rst = 1'b0;
    beat(128'd7, C_PS);
    chk("t6_ps", bus.dout, 128'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
